aes_encrypt_ctrl: RTL and testbench

Iterative AES-128 encryption controller. It accepts one plaintext/key pair through a valid/ready handshake and applies the initial AddRoundKey. It then drives a single shared encryptRound datapath for rounds 1..NR-1, runs a final round without MixColumns, and holds the ciphertext until it is consumed. Round keys are generated on the fly, one per cycle; there is no precomputed key store. The block sits between the accelerator's command interface and the round datapath.

---
 rtl/aes_pkg.sv | 89 ++++++++
 rtl/aes_key_step.sv | 27 ++
 rtl/aes_encrypt_ctrl.sv | 108 ++++++++++
 tb/tb_aes_encrypt_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, constants and byte-level round helpers
// Contents: FSM state enum, NR_AES128, RCON[1:10], S-box lookup, and the
// SubBytes / ShiftRows / MixColumns / AddRoundKey helpers that make up the round datapath.
// Byte 0 of a 128-bit block is bits [127:120]; bytes are column-major (byte r+4c = row r, column c).
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_t;

  localparam int NR_AES128 = 10;

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Row r of the output column c takes the byte from input column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[8*(15-(w+4*c)) +: 8] = s[8*(15-(w+4*((c+w)%4))) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c) +: 8];
      a1 = s[8*(14-4*c) +: 8];
      a2 = s[8*(13-4*c) +: 8];
      a3 = s[8*(12-4*c) +: 8];
      r[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  function automatic logic [127:0] encrypt_round(input logic [127:0] s, input logic [127:0] k);
    return add_round_key(mix_columns(shift_rows(sub_bytes(s))), k);
  endfunction

  function automatic logic [127:0] final_round(input logic [127:0] s, input logic [127:0] k);
    return add_round_key(shift_rows(sub_bytes(s)), k);
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one combinational AES-128 key-expansion step
// Ports: key (current round key), rcon (round constant byte), next_key (following round key).
module aes_key_step (
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);
  import aes_pkg::*;

  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  // RotWord then SubWord on the last word, with rcon folded into the top byte.
  assign t = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_encrypt_ctrl.sv
// rtl/aes_encrypt_ctrl.sv - iterative AES-128 encryption controller
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_pt/in_key job input;
// out_valid/out_ready/out_ct ciphertext output; busy (ROUND or DONE); round_idx (debug).
module aes_encrypt_ctrl #(
  parameter int NR = 10,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pt,
  input  logic [DW-1:0] in_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_ct,
  output logic          busy,
  output logic [3:0]    round_idx
);
  import aes_pkg::*;

  if (NR != NR_AES128) begin : g_bad_nr
    $error("aes_encrypt_ctrl: only NR=10 (AES-128) is supported");
  end
  if (DW != 128) begin : g_bad_dw
    $error("aes_encrypt_ctrl: DW must be 128");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  aes_state_t    fsm;
  logic [127:0]  state_q, key_q, rk;
  logic [7:0]    rc;

  // round_idx is only 1..NR while rc matters; other values map to zero.
  always_comb begin
    rc = 8'h00;
    if (round_idx != 4'd0 && round_idx <= LAST_ROUND) rc = RCON[round_idx];
  end

  aes_key_step u_key_step (
    .key      (key_q),
    .rcon     (rc),
    .next_key (rk)
  );

  // Intermediate round state never leaves the block; only the finished block is shown.
  assign out_ct = out_valid ? state_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      round_idx <= 4'd0;
      state_q   <= '0;
      key_q     <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_q   <= in_pt ^ in_key;
            key_q     <= in_key;
            round_idx <= 4'd1;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            fsm       <= ROUND;
          end
        end
        ROUND: begin
          key_q <= rk;
          if (round_idx == LAST_ROUND) begin
            // Final round skips MixColumns; round_idx stays at NR while the result is held.
            state_q   <= final_round(state_q, rk);
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            state_q   <= encrypt_round(state_q, rk);
            round_idx <= round_idx + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            // Scrub key material and the ciphertext once it has been taken.
            state_q   <= '0;
            key_q     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            round_idx <= 4'd0;
            fsm       <= IDLE;
          end
        end
        default: begin
          fsm       <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          round_idx <= 4'd0;
          state_q   <= '0;
          key_q     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// tb/tb_aes_encrypt_ctrl.sv - self-checking bench for aes_encrypt_ctrl with a byte-array AES reference
module tb_aes_encrypt_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_pt;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_ct;
  logic         busy;
  logic [3:0]   round_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_q [$];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_encrypt_ctrl #(.NR(10), .DW(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pt     (in_pt),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: GF(2^8) arithmetic on byte arrays ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box = multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   k [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc = 8'h01;
    logic [127:0] res = '0;
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
      k[i] = key[127-8*i -: 8];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_ref[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[r+4*c] = gmul(8'h02, t[r+4*c]) ^ gmul(8'h03, t[((r+1)%4)+4*c])
                     ^ t[((r+2)%4)+4*c] ^ t[((r+3)%4)+4*c];
      end
      tmp[0] = sbox_ref[k[13]] ^ rc;
      tmp[1] = sbox_ref[k[14]];
      tmp[2] = sbox_ref[k[15]];
      tmp[3] = sbox_ref[k[12]];
      for (int i = 0; i < 4; i++) k[i] ^= tmp[i];
      for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) s[i] ^= k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers (entered and left at a falling edge) ----------------
  task automatic start_job(input logic [127:0] pt, input logic [127:0] key);
    int n = 0;
    in_pt = pt;
    in_key = key;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 128'(n < 100), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat counts rising edges from the accept edge (inclusive) to out_valid visible.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("done_wait", 128'(out_valid), 128'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("consumed_out_valid", 128'(out_valid), 128'd0);
    check("consumed_in_ready", 128'(in_ready), 128'd1);
  endtask

  task automatic run_job(input string tag, input logic [127:0] pt, input logic [127:0] key,
                         input logic [127:0] exp);
    int lat;
    start_job(pt, key);
    wait_done(lat);
    check({tag, "_latency"}, 128'(lat), 128'd11);
    check({tag, "_ct"}, out_ct, exp);
    check({tag, "_in_ready_low"}, 128'(in_ready), 128'd0);
    consume();
  endtask

  initial begin
    int lat;
    int n;
    int acc_prev;
    int sent;
    int done;
    logic [127:0] held;
    logic [127:0] pt;
    logic [127:0] key;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_pt = '0;
    in_key = '0;
    build_sbox();
    repeat (3) @(negedge clk);

    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_round_idx", 128'(round_idx), 128'd0);
    check("reset_out_ct", out_ct, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    run_job("fips_b", PT_B, KEY_B, CT_B);

    // App. C.1 with round_idx trace 1..10
    start_job(PT_C, KEY_C);
    for (int k = 1; k <= 10; k++) begin
      check("c1_round_idx", 128'(round_idx), 128'(k));
      check("c1_busy", 128'(busy), 128'd1);
      @(negedge clk);
    end
    check("c1_out_valid", 128'(out_valid), 128'd1);
    check("c1_ct", out_ct, CT_C);
    consume();
    check("c1_round_idx_idle", 128'(round_idx), 128'd0);

    // All-zero vector held for 5 cycles
    start_job('0, '0);
    wait_done(lat);
    check("zero_latency", 128'(lat), 128'd11);
    held = out_ct;
    check("zero_ct", held, CT_Z);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_ct", out_ct, CT_Z);
      check("hold_out_valid", 128'(out_valid), 128'd1);
      check("hold_in_ready", 128'(in_ready), 128'd0);
      check("hold_busy", 128'(busy), 128'd1);
    end
    consume();

    // in_valid with a second job while busy is ignored
    start_job(PT_B, KEY_B);
    repeat (2) @(negedge clk);
    in_pt = PT_C;
    in_key = KEY_C;
    in_valid = 1'b1;
    wait_done(lat);
    check("ign_ct", out_ct, CT_B);
    check("ign_in_ready", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ign_idle_in_ready", 128'(in_ready), 128'd1);
    check("ign_idle_busy", 128'(busy), 128'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("ign_second_accepted", 128'(round_idx), 128'd1);
    wait_done(lat);
    check("ign_second_latency", 128'(lat), 128'd11);
    check("ign_second_ct", out_ct, CT_C);
    consume();

    // Reset at round 6, with in_valid held during the reset edge
    start_job(PT_B, KEY_B);
    n = 0;
    while (round_idx != 4'd6 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_round6", 128'(round_idx), 128'd6);
    rst = 1'b1;
    in_pt = PT_C;
    in_key = KEY_C;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_round_idx", 128'(round_idx), 128'd0);
    check("midrst_out_ct", out_ct, 128'd0);
    run_job("after_rst_b", PT_B, KEY_B, CT_B);

    // Random single jobs against the reference model
    for (int j = 0; j < 4; j++) begin
      pt = rand128();
      key = rand128();
      run_job("rand", pt, key, aes_ref(pt, key));
    end

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    acc_prev = -1;
    sent = 0;
    done = 0;
    in_pt = rand128();
    in_key = rand128();
    in_valid = 1'b1;
    for (int t = 0; t < 200 && done < 4; t++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("b2b_unexpected_out", out_ct, 128'd0 - 128'd1);
        else check("b2b_ct", out_ct, exp_q.pop_front());
        done++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(aes_ref(in_pt, in_key));
        if (acc_prev >= 0) check("b2b_spacing", 128'(cyc - acc_prev), 128'd12);
        acc_prev = cyc;
        sent++;
        @(posedge clk);
        #1;
        if (sent < 4) begin
          in_pt = rand128();
          in_key = rand128();
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_jobs_done", 128'(done), 128'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
